// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: operand typedefs, primary opcode
// constants, the request FSM state encoding and a memory-op classifier.
package mem_stage_pkg;

   typedef logic [31:0] i32;
   typedef logic [5:0]  i6;
   typedef logic [4:0]  i5;
   typedef logic [3:0]  i4;

   localparam i6 OP_LW  = 6'h23;
   localparam i6 OP_SW  = 6'h2b;
   localparam i6 OP_SPE = 6'h1c;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_t;

   function automatic logic is_mem_op(input i6 op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus interface between the memory stage (master) and memory (slave).
// Handshake: the master holds dreq_valid with addr/strobe/data stable until
// the slave raises dresp_addr_ok in the same cycle (request accepted). The
// data phase ends on the first cycle with dresp_data_ok at or after that
// acceptance; dresp_data is only meaningful in that cycle. A dresp_data_ok
// seen before acceptance carries no meaning and is ignored by the master.
//   dreq_valid/addr/strobe/data : master -> slave, request phase
//   dresp_addr_ok/data_ok/data  : slave -> master, response phase
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic dreq_valid;
   i32   dreq_addr;
   i4    dreq_strobe;
   i32   dreq_data;
   logic dresp_addr_ok;
   logic dresp_data_ok;
   i32   dresp_data;

   modport master (
      output dreq_valid, dreq_addr, dreq_strobe, dreq_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_addr, dreq_strobe, dreq_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data
   );

endinterface

// File: rtl/mem_req_fsm.sv
// Bus request sequencer for the memory stage plus its hang-detection counter.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   start         a LW/SW that needs the bus is being captured this edge
//   addr_ok       slave accepted the request
//   data_ok       slave completed the data phase
//   dreq_valid    request valid (REQ state)
//   completing    access finishes on the coming edge
//   busy          an access is in flight (REQ or WAIT)
//   timeout       sticky: MAX_WAIT busy cycles have elapsed
//   state         current FSM state, for observation
module mem_req_fsm
   import mem_stage_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       addr_ok,
   input  logic       data_ok,
   output logic       dreq_valid,
   output logic       completing,
   output logic       busy,
   output logic       timeout,
   output mem_state_t state
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   mem_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_inc;

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // A completing access hands straight over to the next LW/SW if one is
   // being captured on the same edge, so back-to-back requests lose no cycle.
   always_comb begin
      state_d    = state_q;
      completing = 1'b0;
      dreq_valid = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = REQ;
         REQ: begin
            dreq_valid = 1'b1;
            if (addr_ok && data_ok) begin
               completing = 1'b1;
               state_d    = start ? REQ : IDLE;
            end else if (addr_ok) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (data_ok) begin
               completing = 1'b1;
               state_d    = start ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign state = state_q;

   assign cnt_inc = (cnt_q == CW'(MAX_WAIT)) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q   <= '0;
         timeout <= 1'b0;
      end else begin
         if (busy && !completing) cnt_q <= cnt_inc;
         else                     cnt_q <= '0;
         if (busy && (cnt_inc == CW'(MAX_WAIT))) timeout <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the execute result, runs the LW/SW bus
// access, stalls upstream while it is in flight and presents the write-back
// record (w_*).
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   e_pc/val3/valt       execute pc, ALU result or address, store data
//   e_icode/dst/req      opcode, destination (0 = none), byte strobe
//   dbus (master)        data bus request/response, see mem_stage_if
//   m_stall              freeze execute and earlier stages
//   w_valid/pc/val/dst/icode  write-back record
//   m_timeout            sticky bus-hang flag
//   m_misalign           misaligned LW/SW flag (only with MEM_ALIGN_CHECK_EN)
//   m_state              request FSM state, for observation
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned LW/SW without
// touching the bus.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic         clk,
   input  logic         resetn,
   input  i32           e_pc,
   input  i32           e_val3,
   input  i32           e_valt,
   input  i6            e_icode,
   input  i5            e_dst,
   input  i4            e_req,
   mem_stage_if.master  dbus,
   output logic         m_stall,
   output logic         w_valid,
   output i32           w_pc,
   output i32           w_val,
   output i5            w_dst,
   output i6            w_icode,
   output logic         m_timeout,
`ifdef MEM_ALIGN_CHECK_EN
   output logic         m_misalign,
`endif
   output mem_state_t   m_state
);

   i32   s_pc, s_val3, s_valt;
   i6    s_icode;
   i5    s_dst;
   i4    s_req;
   logic start, completing, busy, fsm_dreq_valid;
   logic s_misal;

`ifdef MEM_ALIGN_CHECK_EN
   logic e_misal;
   assign e_misal = is_mem_op(e_icode) && (e_val3[1:0] != 2'b00);
`else
   logic e_misal;
   assign e_misal = 1'b0;
`endif

   // Only aligned (or unchecked) memory ops go to the bus.
   assign start = is_mem_op(e_icode) && !e_misal;

   mem_req_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .addr_ok    (dbus.dresp_addr_ok),
      .data_ok    (dbus.dresp_data_ok),
      .dreq_valid (fsm_dreq_valid),
      .completing (completing),
      .busy       (busy),
      .timeout    (m_timeout),
      .state      (m_state)
   );

   assign m_stall          = busy && !completing;
   assign dbus.dreq_valid  = fsm_dreq_valid;
   assign dbus.dreq_addr   = s_val3;
   assign dbus.dreq_strobe = s_req;
   assign dbus.dreq_data   = s_valt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s_pc    <= '0;
         s_val3  <= '0;
         s_valt  <= '0;
         s_icode <= '0;
         s_dst   <= '0;
         s_req   <= '0;
         s_misal <= 1'b0;
      end else if (!m_stall) begin
         s_pc    <= e_pc;
         s_val3  <= e_val3;
         s_valt  <= e_valt;
         s_icode <= e_icode;
         s_dst   <= e_dst;
         s_req   <= e_req;
         s_misal <= e_misal;
      end
   end

   // While busy the record only updates on the completing edge. When idle the
   // stage regs hold a non-bus instruction (or a rejected misaligned one), which
   // retires one cycle after capture.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         w_valid <= 1'b0;
         w_pc    <= '0;
         w_val   <= '0;
         w_dst   <= '0;
         w_icode <= '0;
      end else if (busy) begin
         if (completing) begin
            w_valid <= 1'b1;
            w_pc    <= s_pc;
            w_val   <= (s_icode == OP_LW) ? dbus.dresp_data : s_val3;
            w_dst   <= (s_icode == OP_SW) ? '0 : s_dst;
            w_icode <= s_icode;
         end else begin
            w_valid <= 1'b0;
         end
      end else begin
         w_valid <= (s_icode != '0);
         w_pc    <= s_pc;
         w_val   <= s_val3;
         w_dst   <= s_misal ? '0 : s_dst;
         w_icode <= s_icode;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (!resetn) m_misalign <= 1'b0;
      else         m_misalign <= !busy && s_misal;
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of non-memory vectors plus hand-written
// LW/SW, timeout, reset-abort and back-to-back sequences.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int MAX_WAIT = 4;

   // clock / reset
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   i32 e_pc, e_val3, e_valt;
   i6  e_icode;
   i5  e_dst;
   i4  e_req;
   logic m_stall, w_valid, m_timeout;
   i32 w_pc, w_val;
   i5  w_dst;
   i6  w_icode;
   mem_state_t m_state;
`ifdef MEM_ALIGN_CHECK_EN
   logic m_misalign;
`endif

   mem_stage_if dbus ();

   mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .e_pc       (e_pc),
      .e_val3     (e_val3),
      .e_valt     (e_valt),
      .e_icode    (e_icode),
      .e_dst      (e_dst),
      .e_req      (e_req),
      .dbus       (dbus),
      .m_stall    (m_stall),
      .w_valid    (w_valid),
      .w_pc       (w_pc),
      .w_val      (w_val),
      .w_dst      (w_dst),
      .w_icode    (w_icode),
      .m_timeout  (m_timeout),
`ifdef MEM_ALIGN_CHECK_EN
      .m_misalign (m_misalign),
`endif
      .m_state    (m_state)
   );

   // scoreboard
   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_e(input i32 pc, input i6 icode, input i32 val3, input i32 valt,
                          input i5 dst, input i4 req);
      e_pc = pc; e_icode = icode; e_val3 = val3; e_valt = valt; e_dst = dst; e_req = req;
   endtask

   task automatic bubble();
      drive_e(32'h0, 6'h0, 32'h0, 32'h0, 5'h0, 4'h0);
   endtask

   task automatic bus(input logic aok, input logic dok, input i32 data);
      dbus.dresp_addr_ok = aok;
      dbus.dresp_data_ok = dok;
      dbus.dresp_data    = data;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      bubble();
      bus(1'b0, 1'b0, 32'h0);
      tick();
      tick();
      resetn = 1'b1;
   endtask

   typedef struct {
      i32   pc;
      i6    icode;
      i32   val3;
      i5    dst;
      logic exp_valid;
      i32   exp_val;
      i5    exp_dst;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{32'h1000, 6'h09,  32'h0000_1234, 5'd5,  1'b1, 32'h0000_1234, 5'd5};
      vecs[1] = '{32'h0000, 6'h00,  32'h0000_0000, 5'd0,  1'b0, 32'h0000_0000, 5'd0};
      vecs[2] = '{32'h1008, 6'h0d,  32'hFFFF_0000, 5'd31, 1'b1, 32'hFFFF_0000, 5'd31};
      vecs[3] = '{32'h100c, OP_SPE, 32'h0000_0007, 5'd0,  1'b1, 32'h0000_0007, 5'd0};
      vecs[4] = '{32'h1010, 6'h0f,  32'h8000_0000, 5'd1,  1'b1, 32'h8000_0000, 5'd1};

      // reset state
      resetn = 1'b0;
      bubble();
      bus(1'b0, 1'b0, 32'h0);
      tick();
      tick();
      check("rst_w_valid", w_valid, 1'b0);
      check("rst_m_stall", m_stall, 1'b0);
      check("rst_dreq_valid", dbus.dreq_valid, 1'b0);
      check("rst_timeout", m_timeout, 1'b0);
      check("rst_w_val", w_val, 32'h0);
      check("rst_state", m_state, IDLE);
      resetn = 1'b1;

      // non-memory vectors: capture, then record appears one edge later
      for (int i = 0; i < 5; i++) begin
         drive_e(vecs[i].pc, vecs[i].icode, vecs[i].val3, 32'h0, vecs[i].dst, 4'h0);
         tick();
         bubble();
         #1;
         check("vec_m_stall", m_stall, 1'b0);
         check("vec_dreq_valid", dbus.dreq_valid, 1'b0);
         tick();
         check("vec_w_valid", w_valid, vecs[i].exp_valid);
         if (vecs[i].exp_valid) begin
            check("vec_w_val", w_val, vecs[i].exp_val);
            check("vec_w_dst", w_dst, vecs[i].exp_dst);
            check("vec_w_pc", w_pc, vecs[i].pc);
            check("vec_w_icode", w_icode, vecs[i].icode);
         end
      end

      // LW with addr_ok and data_ok in the first REQ cycle
      do_reset();
      drive_e(32'h100, OP_LW, 32'h80, 32'h0, 5'd7, 4'h0);
      tick();
      bubble();
      bus(1'b1, 1'b1, 32'hDEAD_BEEF);
      #1;
      check("lw_dreq_valid", dbus.dreq_valid, 1'b1);
      check("lw_dreq_addr", dbus.dreq_addr, 32'h80);
      check("lw_dreq_strobe", dbus.dreq_strobe, 4'h0);
      check("lw_m_stall_completing", m_stall, 1'b0);
      tick();
      bus(1'b0, 1'b0, 32'h0);
      #1;
      check("lw_w_valid", w_valid, 1'b1);
      check("lw_w_val", w_val, 32'hDEAD_BEEF);
      check("lw_w_dst", w_dst, 5'd7);
      check("lw_w_pc", w_pc, 32'h100);
      check("lw_dreq_after", dbus.dreq_valid, 1'b0);

      // SW: early data_ok ignored, addr_ok on cycle 3, data_ok on cycle 5
      do_reset();
      drive_e(32'h200, OP_SW, 32'h40, 32'hA5A5_A5A5, 5'd9, 4'hF);
      tick();
      bubble();
      for (int i = 0; i < 6; i++) begin
         bus(i == 3, (i == 1) || (i == 5), 32'h0);
         #1;
         check("sw_dreq_valid", dbus.dreq_valid, (i <= 3));
         check("sw_state", m_state, (i <= 3) ? REQ : WAIT);
         check("sw_m_stall", m_stall, (i < 5));
         if (i <= 3) begin
            check("sw_dreq_addr", dbus.dreq_addr, 32'h40);
            check("sw_dreq_data", dbus.dreq_data, 32'hA5A5_A5A5);
            check("sw_dreq_strobe", dbus.dreq_strobe, 4'hF);
         end
         tick();
      end
      bus(1'b0, 1'b0, 32'h0);
      #1;
      check("sw_w_valid", w_valid, 1'b1);
      check("sw_w_dst", w_dst, 5'd0);
      check("sw_w_val", w_val, 32'h40);
      check("sw_w_icode", w_icode, OP_SW);
      check("sw_w_pc", w_pc, 32'h200);
      check("sw_timeout", m_timeout, 1'b1);
      check("sw_state_idle", m_state, IDLE);

      // silent bus: timeout rises on busy cycle 4 and sticks; reset clears
      do_reset();
      drive_e(32'h300, OP_LW, 32'h10, 32'h0, 5'd2, 4'h0);
      tick();
      bubble();
      for (int i = 0; i < 7; i++) begin
         check("to_timeout", m_timeout, (i >= 4));
         check("to_dreq_valid", dbus.dreq_valid, 1'b1);
         check("to_m_stall", m_stall, 1'b1);
         tick();
      end
      resetn = 1'b0;
      tick();
      check("to_rst_timeout", m_timeout, 1'b0);
      check("to_rst_dreq_valid", dbus.dreq_valid, 1'b0);
      check("to_rst_m_stall", m_stall, 1'b0);
      check("to_rst_w_valid", w_valid, 1'b0);
      check("to_rst_state", m_state, IDLE);
      resetn = 1'b1;

      // reset during WAIT aborts; a late data_ok is ignored
      do_reset();
      drive_e(32'h400, OP_LW, 32'h20, 32'h0, 5'd3, 4'h0);
      tick();
      bubble();
      bus(1'b1, 1'b0, 32'h0);
      #1;
      check("abort_dreq_valid", dbus.dreq_valid, 1'b1);
      tick();
      bus(1'b0, 1'b0, 32'h0);
      #1;
      check("abort_state_wait", m_state, WAIT);
      check("abort_m_stall", m_stall, 1'b1);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      #1;
      check("abort_state", m_state, IDLE);
      check("abort_m_stall_rst", m_stall, 1'b0);
      check("abort_w_valid", w_valid, 1'b0);
      bus(1'b0, 1'b1, 32'hCAFE_F00D);
      tick();
      bus(1'b0, 1'b0, 32'h0);
      #1;
      check("abort_late_w_valid", w_valid, 1'b0);
      check("abort_late_state", m_state, IDLE);

      // back-to-back LW then SW
      do_reset();
      drive_e(32'h500, OP_LW, 32'h84, 32'h0, 5'd4, 4'h0);
      tick();
      drive_e(32'h504, OP_SW, 32'h44, 32'h5555_AAAA, 5'd2, 4'hF);
      bus(1'b1, 1'b1, 32'h1111_2222);
      #1;
      check("b2b_lw_addr", dbus.dreq_addr, 32'h84);
      check("b2b_lw_strobe", dbus.dreq_strobe, 4'h0);
      exp_q.push_back(32'h1111_2222);
      tick();
      bubble();
      bus(1'b1, 1'b1, 32'h0);
      #1;
      check("b2b_lw_w_valid", w_valid, 1'b1);
      check("b2b_lw_w_val", w_val, exp_q.pop_front());
      check("b2b_lw_w_dst", w_dst, 5'd4);
      check("b2b_sw_dreq_valid", dbus.dreq_valid, 1'b1);
      check("b2b_sw_addr", dbus.dreq_addr, 32'h44);
      check("b2b_sw_strobe", dbus.dreq_strobe, 4'hF);
      check("b2b_sw_data", dbus.dreq_data, 32'h5555_AAAA);
      exp_q.push_back(32'h44);
      tick();
      bus(1'b0, 1'b0, 32'h0);
      #1;
      check("b2b_sw_w_valid", w_valid, 1'b1);
      check("b2b_sw_w_val", w_val, exp_q.pop_front());
      check("b2b_sw_w_dst", w_dst, 5'd0);
      check("b2b_sw_w_pc", w_pc, 32'h504);
      tick();
      check("b2b_bubble_w_valid", w_valid, 1'b0);

      // misaligned LW
      do_reset();
      drive_e(32'h600, OP_LW, 32'h82, 32'h0, 5'd6, 4'h0);
      tick();
      bubble();
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      check("mis_dreq_valid", dbus.dreq_valid, 1'b0);
      check("mis_m_stall", m_stall, 1'b0);
      check("mis_state", m_state, IDLE);
      tick();
      check("mis_flag", m_misalign, 1'b1);
      check("mis_w_valid", w_valid, 1'b1);
      check("mis_w_dst", w_dst, 5'd0);
      check("mis_dreq_after", dbus.dreq_valid, 1'b0);
      tick();
      check("mis_flag_clear", m_misalign, 1'b0);
`else
      check("mis_dreq_valid", dbus.dreq_valid, 1'b1);
      check("mis_dreq_addr", dbus.dreq_addr, 32'h82);
      bus(1'b1, 1'b1, 32'h0BAD_0BAD);
      tick();
      bus(1'b0, 1'b0, 32'h0);
      #1;
      check("mis_w_val", w_val, 32'h0BAD_0BAD);
      check("mis_w_dst", w_dst, 5'd6);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
